// File: rtl/nanci_pkg.sv
// Shared encodings, FSM states and the record compare key for the Nanci mesh sort PEs.
package nanci_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_TAKE = 2'b01;
    localparam logic [1:0] OP_MIN  = 2'b10;
    localparam logic [1:0] OP_MAX  = 2'b11;

    localparam logic [1:0] DIR_L = 2'b00;
    localparam logic [1:0] DIR_R = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers zero-extend their fields, so one key type serves every PE width.
    localparam int KEY_FIELD_W = 32;

    typedef struct packed {
        logic [KEY_FIELD_W-1:0] data;
        logic [KEY_FIELD_W-1:0] addr;
    } key_t;

    function automatic logic less_than(input key_t a, input key_t b);
        return (a.data < b.data) || ((a.data == b.data) && (a.addr < b.addr));
    endfunction

endpackage

// File: rtl/nanci_cex_unit.sv
// Combinational move / compare-exchange against one of four neighbour links.
module nanci_cex_unit
    import nanci_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter logic [3:0] EDGE_MASK = 4'b0000
) (
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] cur,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] nb_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] nb_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] nb_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] nb_d,
    input  logic [3:0]                       prog_op,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] rec_next,
    output logic                             changed
);

    localparam int W = ADDR_WIDTH + DATA_WIDTH;

    logic [W-1:0] links [4];
    logic [3:0]   link_ok;
    logic [1:0]   dir;
    logic [1:0]   op;
    logic [W-1:0] nb;
    key_t         cur_key;
    key_t         nb_key;

    assign links[DIR_L] = nb_l;
    assign links[DIR_R] = nb_r;
    assign links[DIR_U] = nb_u;
    assign links[DIR_D] = nb_d;

    // A link that sits on the mesh boundary never drives the record.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_link
            assign link_ok[gi] = ~EDGE_MASK[gi];
        end
    endgenerate

    assign dir = prog_op[3:2];
    assign op  = prog_op[1:0];
    assign nb  = links[dir];

    assign cur_key.data = KEY_FIELD_W'(cur[DATA_WIDTH-1:0]);
    assign cur_key.addr = KEY_FIELD_W'(cur[W-1:DATA_WIDTH]);
    assign nb_key.data  = KEY_FIELD_W'(nb[DATA_WIDTH-1:0]);
    assign nb_key.addr  = KEY_FIELD_W'(nb[W-1:DATA_WIDTH]);

    always_comb begin
        rec_next = cur;
        if (link_ok[dir]) begin
            case (op)
                OP_TAKE: rec_next = nb;
                OP_MIN:  if (less_than(nb_key, cur_key)) rec_next = nb;
                OP_MAX:  if (less_than(cur_key, nb_key)) rec_next = nb;
                default: rec_next = cur;
            endcase
        end
    end

    assign changed = (rec_next != cur);

endmodule

// File: rtl/nanci_pe_seq.sv
// Nanci mesh sort PE running a locally stored step program against its four neighbours.
// Optional swap counter output o_swap_cnt is built when NANCI_SWAP_CNT_EN is defined.
module nanci_pe_seq
    import nanci_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter int PROG_DEPTH = 8,
    parameter int SORT_CYCLES = 1,
    parameter logic [3:0] EDGE_MASK = 4'b0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_d,
    input  logic                               i_load,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_load_word,
    input  logic                               i_prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0]      i_prog_addr,
    input  logic [3:0]                         i_prog_op,
    input  logic [$clog2(PROG_DEPTH):0]        i_prog_len,
    input  logic                               i_start,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]   o_PE,
    output logic                               o_busy,
    output logic                               o_done
`ifdef NANCI_SWAP_CNT_EN
    ,
    output logic [$clog2(PROG_DEPTH):0]        o_swap_cnt
`endif
);

    localparam int W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int PW = $clog2(PROG_DEPTH);
    localparam int CW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SORT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [PW-1:0] STEP_ONE = PW'(1);
    localparam logic [PW:0]   LEN_ONE  = (PW+1)'(1);

    state_t        state_reg;
    logic [W-1:0]  pe_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [PW-1:0] step_reg;
    logic [CW-1:0] cyc_reg;
    logic [PW:0]   len_reg;

    logic [3:0]    prog_mem [PROG_DEPTH];
    logic [3:0]    op_reg;
    logic [PW-1:0] rd_addr;
    logic          prog_wr;
    logic          latch;
    logic          last_step;
    logic [W-1:0]  cex_next;
    logic          cex_changed;

    assign prog_wr   = (state_reg == IDLE) && i_prog_we && !i_load && !rst;
    assign latch     = (state_reg == RUN) && (cyc_reg == CYC_LAST);
    assign last_step = ({1'b0, step_reg} == (len_reg - LEN_ONE));

    // Read address tracks the step the register will hold next, so op_reg
    // already carries prog[step] when the latch edge arrives.
    always_comb begin
        rd_addr = '0;
        if (state_reg == RUN) begin
            rd_addr = (latch && !last_step) ? (step_reg + STEP_ONE) : step_reg;
        end
    end

    // Write-through bypass covers a program write on the same edge as i_start.
    always_ff @(posedge clk) begin
        if (prog_wr) begin
            prog_mem[i_prog_addr] <= i_prog_op;
        end
        op_reg <= (prog_wr && (i_prog_addr == rd_addr)) ? i_prog_op : prog_mem[rd_addr];
    end

    nanci_cex_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_MASK  (EDGE_MASK)
    ) u_cex (
        .cur      (pe_reg),
        .nb_l     (i_PE_l),
        .nb_r     (i_PE_r),
        .nb_u     (i_PE_u),
        .nb_d     (i_PE_d),
        .prog_op  (op_reg),
        .rec_next (cex_next),
        .changed  (cex_changed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pe_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            step_reg  <= '0;
            cyc_reg   <= '0;
            len_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_load) begin
                        pe_reg <= i_load_word;
                    end
                    if (i_start) begin
                        len_reg  <= i_prog_len;
                        step_reg <= '0;
                        cyc_reg  <= '0;
                        if (i_prog_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cyc_reg == CYC_LAST) begin
                        pe_reg  <= cex_next;
                        cyc_reg <= '0;
                        if (last_step) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            step_reg  <= '0;
                        end else begin
                            step_reg <= step_reg + STEP_ONE;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CYC_ONE;
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_PE   = pe_reg;
    assign o_busy = busy_reg;
    assign o_done = done_reg;

`ifdef NANCI_SWAP_CNT_EN
    logic [PW:0] swap_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && i_start) begin
            swap_cnt_reg <= '0;
        end else if (latch && cex_changed) begin
            swap_cnt_reg <= swap_cnt_reg + LEN_ONE;
        end
    end

    assign o_swap_cnt = swap_cnt_reg;
`else
    logic swap_unused;
    assign swap_unused = cex_changed;
`endif

endmodule
